// File: rtl/alu_share_arbiter_if.sv
// Request, ALU-operand and response bundle for the shared ALU operand path.
// slave is the arbiter's view; master is the requesters/ALU side.
interface alu_share_arbiter_if #(
   parameter int WIDTH = 32
) ();
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_imm;
   logic [WIDTH-1:0] req0_rs2;
   logic             req0_use_imm;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_imm;
   logic [WIDTH-1:0] req1_rs2;
   logic             req1_use_imm;

   logic             alu_src_ctrl;
   logic [WIDTH-1:0] alu_immediate;
   logic [WIDTH-1:0] alu_reg_data2;
   logic             alu_start;
   logic [WIDTH-1:0] alu_result;

   logic             resp0_valid;
   logic             resp1_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_data;
   logic             busy;

   modport slave (
      input  req0_valid, req0_imm, req0_rs2, req0_use_imm,
      input  req1_valid, req1_imm, req1_rs2, req1_use_imm,
      input  alu_result, resp_ready,
      output req0_ready, req1_ready,
      output alu_src_ctrl, alu_immediate, alu_reg_data2, alu_start,
      output resp0_valid, resp1_valid, resp_data, busy
   );

   modport master (
      output req0_valid, req0_imm, req0_rs2, req0_use_imm,
      output req1_valid, req1_imm, req1_rs2, req1_use_imm,
      output alu_result, resp_ready,
      input  req0_ready, req1_ready,
      input  alu_src_ctrl, alu_immediate, alu_reg_data2, alu_start,
      input  resp0_valid, resp1_valid, resp_data, busy
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one ALU operand path between the execute stage (req0)
// and the address-generation/branch-target path (req1).
module alu_share_arbiter #(
   parameter int WIDTH   = 32,
   parameter int ALU_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   alu_share_arbiter_if.slave bus
);
   // state | meaning
   // IDLE  | arbitrate, ready to the grantee, latch operands on handshake
   // ISSUE | alu_start pulse, latency timer loaded with ALU_LAT
   // WAIT  | timer counts down, alu_result captured at terminal count
   // RESP  | response valid to the winner until resp_ready
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [2:0] LAT_LOAD = 3'(ALU_LAT);

   state_t           state, state_next;
   logic             ptr;
   logic             winner;
   logic [2:0]       lat_cnt;
   logic             grant0, grant1;
   logic             accept;
   logic             lat_tc;
   logic             resp_done;
   logic             src_ctrl_q;
   logic             start_q;
   logic             resp0_q, resp1_q;
   logic [WIDTH-1:0] imm_q, rs2_q, data_q;

   // With both requesting, the pointer picks; a lone requester always wins.
   assign grant0 = bus.req0_valid && (!bus.req1_valid || !ptr);
   assign grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next     = state;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      accept         = 1'b0;
      resp_done      = 1'b0;
      lat_tc         = (lat_cnt == 3'd1);
      case (state)
         IDLE: begin
            bus.req0_ready = grant0;
            bus.req1_ready = grant1;
            if (grant0 || grant1) begin
               accept     = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (lat_tc) begin
               state_next = RESP;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               resp_done  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= 1'b0;
         winner     <= 1'b0;
         src_ctrl_q <= 1'b0;
         imm_q      <= '0;
         rs2_q      <= '0;
         start_q    <= 1'b0;
         lat_cnt    <= '0;
         resp0_q    <= 1'b0;
         resp1_q    <= 1'b0;
         data_q     <= '0;
      end else begin
         start_q <= 1'b0;
         if (accept) begin
            winner     <= grant1;
            src_ctrl_q <= grant1 ? bus.req1_use_imm : bus.req0_use_imm;
            imm_q      <= grant1 ? bus.req1_imm     : bus.req0_imm;
            rs2_q      <= grant1 ? bus.req1_rs2     : bus.req0_rs2;
            start_q    <= 1'b1;
         end

         if (state == ISSUE) begin
            lat_cnt <= LAT_LOAD;
         end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 3'd1;
         end

         if (state == WAIT && lat_tc) begin
            data_q  <= bus.alu_result;
            resp0_q <= !winner;
            resp1_q <= winner;
         end

         // Pointer moves only on a completed response, so aborted work never skews fairness.
         if (resp_done) begin
            resp0_q <= 1'b0;
            resp1_q <= 1'b0;
            ptr     <= !winner;
         end
      end
   end

   assign bus.alu_src_ctrl  = src_ctrl_q;
   assign bus.alu_immediate = imm_q;
   assign bus.alu_reg_data2 = rs2_q;
   assign bus.alu_start     = start_q;
   assign bus.resp0_valid   = resp0_q;
   assign bus.resp1_valid   = resp1_q;
   assign bus.resp_data     = data_q;
   assign bus.busy          = (state != IDLE);
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Schedules one shared ALU operand path, consisting of the ALU source mux select and operands plus the ALU itself, between two requesters.
- Requester 0 is the execute stage. Requester 1 is the address-generation/branch-target path.
- The block arbitrates round-robin, latches the winner's operands, and drives the mux select and operands stable for the ALU latency.
- It captures the ALU result and returns it to the winner with a valid/ready handshake.

Parameters:
- WIDTH, 32, datapath width of operands and result.
- ALU_LAT, 1, cycles from alu_start to alu_result valid. Legal range is 1..4.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 is accepted this cycle.
- req0_imm  input  WIDTH  requester 0 immediate.
- req0_rs2  input  WIDTH  requester 0 register operand.
- req0_use_imm  input  1  1 selects the immediate, 0 selects rs2.
- req1_valid, req1_ready, req1_imm, req1_rs2, req1_use_imm: same as requester 0, for requester 1.
- alu_src_ctrl  output  1  mux select to the ALU source mux.
- alu_immediate  output  WIDTH  latched immediate to the mux.
- alu_reg_data2  output  WIDTH  latched rs2 to the mux.
- alu_start  output  1  one-cycle pulse starting the ALU operation.
- alu_result  input  WIDTH  ALU output.
- resp0_valid  output  1  result available for requester 0.
- resp1_valid  output  1  result available for requester 1.
- resp_ready  input  1  current responder consumes the result.
- resp_data  output  WIDTH  captured result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE and the priority pointer goes to 0.
  - All registered outputs clear: alu_src_ctrl, alu_immediate, alu_reg_data2, alu_start, resp0_valid, resp1_valid, resp_data all 0.
  - Reset mid-operation abandons the in-flight operation; no response is produced.
- States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - Grant choice: if only one request is valid, grant it. If both are valid, grant the requester the priority pointer names.
  - reqN_ready=1 is combinational, only in IDLE, only for the granted requester, and at most one ready per cycle.
  - On handshake (cycle H), latch the winner's imm, rs2, use_imm and winner id, then go to ISSUE.
  - With no request valid, stay in IDLE; mux outputs hold their last latched values.
- ISSUE (cycle S=H+1):
  - alu_start=1 for exactly this cycle.
  - alu_src_ctrl, alu_immediate and alu_reg_data2 show the latched values.
  - Load the latency counter with ALU_LAT, then go to WAIT.
- WAIT:
  - Counter decrements each cycle.
  - In cycle S+ALU_LAT (counter reaches 1), capture alu_result into resp_data, then go to RESP.
  - Mux outputs stay constant from S through S+ALU_LAT.
- RESP:
  - respN_valid=1 for the winner only, with resp_data stable.
  - Hold until resp_ready=1. On the handshake edge, clear valid, set the priority pointer to the other requester, and return to IDLE.
  - The earliest next acceptance is the cycle after the response handshake; there is no overlap.
- Latency: response is first valid in cycle H+ALU_LAT+2. For ALU_LAT=1, a request accepted at cycle 0 has its response at cycle 3.
- Requests:
  - A request not granted must stay asserted; the block never drops it.
  - Request inputs are ignored outside IDLE.
- The pointer only toggles on completed responses, so a lone requester can be served back-to-back.
- resp_ready while no response is valid is ignored.

Test Plan:
- Reset then single request. After rst, req0_valid=1, imm=0x10, rs2=0x5, use_imm=1, ALU_LAT=1; ALU model adds 0x100.
  - req0_ready=1 at cycle 0.
  - alu_start pulses at cycle 1 with alu_src_ctrl=1 and alu_immediate=0x10.
  - resp0_valid=1 at cycle 3 with resp_data = model output.
  - resp1_valid stays 0.
- Simultaneous requests. req0 and req1 both valid from reset.
  - Order is req0, then req1, then req0: the pointer alternates.
  - Never both readies high in one cycle.
  - Each response routes to the correct respN_valid.
- Response backpressure. Hold resp_ready=0 for 5 cycles in RESP.
  - resp_data and resp0_valid stay stable.
  - No new ready is asserted, and busy=1 throughout.
  - Release resp_ready; IDLE follows on the next cycle.
- Latency sweep. ALU_LAT=4 with use_imm=0, rs2=0xDEADBEEF.
  - alu_reg_data2 and alu_src_ctrl=0 hold for 5 cycles from alu_start.
  - Capture occurs in cycle S+4.
  - Response appears at H+6.
- Reset mid-operation. Assert rst during WAIT.
  - Next cycle is IDLE with all outputs 0 and the pointer at 0.
  - No response valid appears.
  - A subsequent req1-only request is served normally.
- Lone repeated requester. req1_valid held high continuously.
  - Served back-to-back, with each accept one cycle after the prior response handshake.
